// File: rtl/aurora_lane_distribute_pkg.sv
// Shared definitions for the Aurora lane distributor.
//   HDR_DATA / HDR_CTRL : 2-bit sync headers for data and control blocks
//   IDLE_BLOCK          : control block sent when a lane has nothing to carry
//   SERVICE_TAG         : first byte of a periodic service block
//   beat_type_t         : kind of beat loaded into the lane output registers
//   lane_block_t        : one 64-bit Aurora block
//   lane_mask()         : converts "active lanes minus 1" into a per-lane mask
package aurora_lane_pkg;

  localparam int          NUM_LANES   = 4;
  localparam logic [1:0]  HDR_DATA    = 2'b01;
  localparam logic [1:0]  HDR_CTRL    = 2'b10;
  localparam logic [63:0] IDLE_BLOCK  = 64'h7800_0000_0000_0000;
  localparam logic [7:0]  SERVICE_TAG = 8'hB4;

  typedef enum logic [1:0] {
    BT_IDLE,
    BT_DATA,
    BT_SERVICE
  } beat_type_t;

  typedef logic [63:0] lane_block_t;

  // Lane i is active when i <= active_lanes.
  function automatic logic [NUM_LANES-1:0] lane_mask(input logic [1:0] active_lanes);
    logic [NUM_LANES-1:0] m;
    for (int i = 0; i < NUM_LANES; i++) begin
      m[i] = (2'(i) <= active_lanes);
    end
    return m;
  endfunction

endpackage

// File: rtl/aurora_lane_distribute_if.sv
// Read interface of the 256-bit packer store.
//   Empty          : store holds no beat
//   ByteEnableRead : one enable per 32-bit word of DataRead
//   EofRead        : beat closes an event
//   DataRead       : packed beat, word k = bits [32k+31:32k]
//   Read           : consumer takes the beat on this clock edge
// master = packer side, slave = consumer side.
interface aurora_lane_distribute_if;

  logic         Empty;
  logic [7:0]   ByteEnableRead;
  logic         EofRead;
  logic [255:0] DataRead;
  logic         Read;

  modport master (
    output Empty, ByteEnableRead, EofRead, DataRead,
    input  Read
  );

  modport slave (
    input  Empty, ByteEnableRead, EofRead, DataRead,
    output Read
  );

endinterface

// File: rtl/aurora_lane_distribute_block_fmt.sv
// Combinational block formatter for a single lane.
//   beat_type : kind of beat being loaded
//   word_hi   : word placed in bits 63:32 (data word 2i, or service upper half)
//   word_lo   : word placed in bits 31:0  (data word 2i+1, or service lower half)
//   en_hi     : enable of word_hi; a data block exists only when it is set
//   en_lo     : enable of word_lo; when clear the slot is filled with PAD_WORD
//   active    : lane is inside the active mask; inactive lanes always idle
//   header    : sync header for the block
//   block     : 64-bit block
module aurora_lane_block_fmt
  import aurora_lane_pkg::*;
#(
  parameter logic [31:0] PAD_WORD = 32'hFFFF_FFFF
) (
  input  beat_type_t  beat_type,
  input  logic [31:0] word_hi,
  input  logic [31:0] word_lo,
  input  logic        en_hi,
  input  logic        en_lo,
  input  logic        active,
  output logic [1:0]  header,
  output lane_block_t block
);

  always_comb begin
    // NOTE: outputs take a default before any branch so no path leaves them
    // unassigned; that is what keeps this block free of inferred latches.
    header = HDR_CTRL;
    block  = IDLE_BLOCK;
    if (active) begin
      case (beat_type)
        BT_SERVICE: block = {word_hi, word_lo};
        BT_DATA: begin
          if (en_hi) begin
            header = HDR_DATA;
            block  = {word_hi, en_lo ? word_lo : PAD_WORD};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/aurora_lane_distribute.sv
// Aurora lane distributor: splits 256-bit packer beats into up to four
// 64-bit Aurora blocks with sync headers, filling gaps with idle blocks and
// inserting a service block every SERVICE_PERIOD accepted beats.
//   Clk         : clock
//   Reset_b     : synchronous active-low reset
//   ActiveLanes : number of active lanes minus 1, sampled on each load
//   rd          : packer store read interface (slave side)
//   ServiceData : 48-bit payload carried by service blocks
//   LaneReady   : per-lane serializer accept
//   LaneValid   : output beat valid, common to all lanes
//   LaneData    : per-lane 64-bit block
//   LaneHeader  : per-lane 2-bit sync header
//   FrameCount  : accepted data beats carrying EOF, wrapping
//   LaneError   : sticky, an enabled word fell on an inactive lane
module aurora_lane_distribute
  import aurora_lane_pkg::*;
#(
  parameter int unsigned SERVICE_PERIOD = 50,
  parameter logic [31:0] PAD_WORD       = 32'hFFFF_FFFF
) (
  input  logic                        Clk,
  input  logic                        Reset_b,
  input  logic [1:0]                  ActiveLanes,
  aurora_lane_distribute_if.slave     rd,
  input  logic [47:0]                 ServiceData,
  input  logic [NUM_LANES-1:0]        LaneReady,
  output logic                        LaneValid,
  output lane_block_t [NUM_LANES-1:0] LaneData,
  output logic [NUM_LANES-1:0][1:0]   LaneHeader,
  output logic [15:0]                 FrameCount,
  output logic                        LaneError
);

  localparam int SVC_W = (SERVICE_PERIOD > 1) ? $clog2(SERVICE_PERIOD) : 1;
  localparam logic [SVC_W-1:0] SVC_LAST =
    (SERVICE_PERIOD > 0) ? SVC_W'(SERVICE_PERIOD - 1) : '0;

  logic [NUM_LANES-1:0]        mask_d, mask_q;
  beat_type_t                  beat_d, beat_q;
  logic                        eof_q;
  logic [SVC_W-1:0]            svc_cnt;
  logic                        accept, load, svc_due, err_d;
  logic [NUM_LANES-1:0]        lost;
  lane_block_t [NUM_LANES-1:0] blk_d;
  logic [NUM_LANES-1:0][1:0]   hdr_d;

  assign mask_d = lane_mask(ActiveLanes);

  // The held beat is judged against the mask it was loaded with, so a change
  // of ActiveLanes only affects beats loaded afterwards.
  assign accept = LaneValid & (&(LaneReady | ~mask_q));
  assign load   = Reset_b & (~LaneValid | accept);

  // The counter is cleared by the same edge that accepts a held service
  // beat, so while one is held the saturated count is stale and must not
  // trigger a second insertion.
  assign svc_due = (SERVICE_PERIOD != 0) && (svc_cnt == SVC_LAST) &&
                   !(LaneValid && (beat_q == BT_SERVICE));

  always_comb begin
    beat_d = BT_IDLE;
    if (svc_due)        beat_d = BT_SERVICE;
    else if (!rd.Empty) beat_d = BT_DATA;
  end

  assign rd.Read = load & (beat_d == BT_DATA);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [31:0] word_hi, word_lo;
    logic [1:0]  header;
    lane_block_t block;

    assign word_hi = (beat_d == BT_SERVICE) ? {SERVICE_TAG, 8'h00, ServiceData[47:32]}
                                            : rd.DataRead[64*i +: 32];
    assign word_lo = (beat_d == BT_SERVICE) ? ServiceData[31:0]
                                            : rd.DataRead[64*i+32 +: 32];

    assign lost[i] = ~mask_d[i] & (rd.ByteEnableRead[2*i] | rd.ByteEnableRead[2*i+1]);

    aurora_lane_block_fmt #(
      .PAD_WORD (PAD_WORD)
    ) u_fmt (
      .beat_type (beat_d),
      .word_hi   (word_hi),
      .word_lo   (word_lo),
      .en_hi     (rd.ByteEnableRead[2*i]),
      .en_lo     (rd.ByteEnableRead[2*i+1]),
      .active    (mask_d[i]),
      .header    (header),
      .block     (block)
    );

    assign blk_d[i] = block;
    assign hdr_d[i] = header;
  end

  assign err_d = rd.Read & (|lost);

  always_ff @(posedge Clk) begin
    // NOTE: reset is sampled on the clock edge like any other input, and all
    // state is updated with non-blocking assignments so every register sees
    // the pre-edge values of the others.
    if (!Reset_b) begin
      LaneValid  <= 1'b0;
      LaneData   <= {NUM_LANES{IDLE_BLOCK}};
      LaneHeader <= {NUM_LANES{HDR_CTRL}};
      FrameCount <= '0;
      LaneError  <= 1'b0;
      svc_cnt    <= '0;
      mask_q     <= '1;
      beat_q     <= BT_IDLE;
      eof_q      <= 1'b0;
    end else begin
      if (accept) begin
        if (beat_q == BT_SERVICE)  svc_cnt <= '0;
        else if (svc_cnt != SVC_LAST) svc_cnt <= svc_cnt + 1'b1;
        if ((beat_q == BT_DATA) && eof_q) FrameCount <= FrameCount + 16'd1;
      end
      if (load) begin
        LaneValid  <= 1'b1;
        LaneData   <= blk_d;
        LaneHeader <= hdr_d;
        mask_q     <= mask_d;
        beat_q     <= beat_d;
        eof_q      <= rd.EofRead & (beat_d == BT_DATA);
      end
      if (err_d) LaneError <= 1'b1;
    end
  end

endmodule
